display_contador: RTL

- Downstream display stage for the 4-bit up/down counter.
- Consumes the counter's `count` value and its one-cycle wrap pulse, and keeps a tens digit that steps on every wrap.
- Drives a two-digit, time-multiplexed, active-low 7-segment display: units digit in hex, tens digit.
- Shares the counter's clock domain, so no synchronisers are needed.

---
 rtl/display_contador.sv | 120 ++++++++++++
 1 files changed

// File: rtl/display_contador.sv
// Two-digit multiplexed 7-segment display stage: keeps a tens digit stepped by
// the counter's wrap pulse and scans units/tens with blanking gaps between digits.
module display_contador #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned BLANK_CYC   = 2,
  parameter int unsigned MAX_DEZENA  = 9,
  parameter int unsigned BLANK_ZERO  = 1
) (
  input  logic       clk,
  input  logic       resetar,
  input  logic [3:0] count,
  input  logic       wrap,
  input  logic       decrescente,
  output logic [3:0] dezena,
  output logic       ovf,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam int unsigned MAX_DWELL = (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
  localparam int unsigned CNT_W     = ($clog2(MAX_DWELL) < 1) ? 1 : $clog2(MAX_DWELL);
  localparam logic [3:0]  MAX_D     = 4'(MAX_DEZENA);
  localparam logic [6:0]  SEG_OFF   = 7'h7F;
  localparam logic [1:0]  AN_OFF    = 2'b11;

  typedef enum logic [1:0] {UNI, GAP1, DEZ, GAP2} scan_e;

  scan_e            state_q, state_d;
  logic [CNT_W-1:0] refresh_q, refresh_d;
  logic [CNT_W-1:0] last_c;
  logic [3:0]       dezena_q, dezena_d;
  logic             ovf_q, ovf_d;
  logic [6:0]       seg_q, seg_d;
  logic [1:0]       an_q, an_d;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  // State and all registered outputs
  always_ff @(posedge clk) begin
    if (resetar) begin
      state_q   <= UNI;
      refresh_q <= '0;
      dezena_q  <= 4'd0;
      ovf_q     <= 1'b0;
      seg_q     <= SEG_OFF;
      an_q      <= AN_OFF;
    end else begin
      state_q   <= state_d;
      refresh_q <= refresh_d;
      dezena_q  <= dezena_d;
      ovf_q     <= ovf_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end

  // Scan sequencing: dwell per state, then advance
  always_comb begin
    state_d   = state_q;
    refresh_d = refresh_q + CNT_W'(1);
    last_c    = ((state_q == UNI) || (state_q == DEZ)) ? CNT_W'(REFRESH_DIV - 1)
                                                       : CNT_W'(BLANK_CYC - 1);
    if (refresh_q == last_c) begin
      refresh_d = '0;
      case (state_q)
        UNI:     state_d = GAP1;
        GAP1:    state_d = DEZ;
        DEZ:     state_d = GAP2;
        default: state_d = UNI;
      endcase
    end
  end

  // Digit drive decoded from the current scan state
  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    case (state_q)
      UNI: begin
        an_d  = 2'b10;
        seg_d = hex7(count);
      end
      DEZ: begin
        if (!((BLANK_ZERO != 0) && (dezena_q == 4'd0))) begin
          an_d  = 2'b01;
          seg_d = hex7(dezena_q);
        end
      end
      default: ;
    endcase
  end

  // Tens digit with wrap-around and overflow pulse
  always_comb begin
    dezena_d = dezena_q;
    ovf_d    = 1'b0;
    if (wrap) begin
      if (!decrescente) begin
        ovf_d    = (dezena_q == MAX_D);
        dezena_d = ovf_d ? 4'd0 : dezena_q + 4'd1;
      end else begin
        ovf_d    = (dezena_q == 4'd0);
        dezena_d = ovf_d ? MAX_D : dezena_q - 4'd1;
      end
    end
  end

  assign dezena = dezena_q;
  assign ovf    = ovf_q;
  assign seg    = seg_q;
  assign an     = an_q;

endmodule
